// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats and
// small opcode classification helpers used by the decode stage.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    function automatic logic opc_legal(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM:
                opc_legal = 1'b1;
            default: opc_legal = 1'b0;
        endcase
    endfunction

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP:
                opc_writes_rd = 1'b1;
            default: opc_writes_rd = 1'b0;
        endcase
    endfunction

    // rs1 is treated as read for every opcode except the pure-immediate forms,
    // so unknown encodings stall conservatively behind loads.
    function automatic logic opc_uses_rs1(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: opc_uses_rs1 = 1'b0;
            default:                     opc_uses_rs1 = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: classifies the instruction format
// and produces the sign-extended 32-bit immediate.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output imm_fmt_e    fmt
);

    // Format selection from the opcode field
    always_comb begin
        fmt = IMM_NONE;
        case (instr[6:0])
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: fmt = IMM_I;
            OPC_STORE:                                                fmt = IMM_S;
            OPC_BRANCH:                                               fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                                       fmt = IMM_U;
            OPC_JAL:                                                  fmt = IMM_J;
            default:                                                  fmt = IMM_NONE;
        endcase
    end

    // Immediate assembly per format
    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage: decodes the fetched instruction, reads the
// regfile with writeback bypass, and stalls dependents of in-flight loads.
module id_operand_stage
    import rv32i_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int XLEN     = rv32i_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] op_a_o,
    output logic [XLEN-1:0] op_b_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rd_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic            funct7b5_o,
    output logic            reg_write_o,
    output logic            illegal_o
);

    localparam logic [1:0] LOAD_LAT_C = 2'(LOAD_LAT);

    logic [6:0]      opcode_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [31:0]     imm_s;
    imm_fmt_e        fmt_s;
    logic            rs1_use_s;
    logic            rs2_use_s;
    logic            legal_s;
    logic            reg_write_s;
    logic            hazard_s;
    logic            fire_in_s;
    logic            fire_out_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;

    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] op_a_r;
    logic [XLEN-1:0] op_b_r;
    logic [XLEN-1:0] imm_r;
    logic [4:0]      rd_r;
    logic [6:0]      opcode_r;
    logic [2:0]      funct3_r;
    logic            funct7b5_r;
    logic            reg_write_r;
    logic            illegal_r;
    logic [4:0]      load_rd_r;
    logic [1:0]      cnt_r;

    imm_gen u_imm_gen (
        .instr (instr_i),
        .imm   (imm_s),
        .fmt   (fmt_s)
    );

    assign opcode_s    = instr_i[6:0];
    assign rs1_s       = instr_i[19:15];
    assign rs2_s       = instr_i[24:20];
    assign rs1_use_s   = opc_uses_rs1(opcode_s);
    // Only S, B and register-register forms read rs2.
    assign rs2_use_s   = (fmt_s == IMM_S) || (fmt_s == IMM_B) || (opcode_s == OPC_OP);
    assign legal_s     = opc_legal(opcode_s);
    assign reg_write_s = opc_writes_rd(opcode_s) & legal_s;

    assign fire_in_s   = valid_i & ready_o;
    assign fire_out_s  = valid_r & ready_i;

    // Load-use hazard against the load in this stage or one that just left
    always_comb begin
        hazard_s = 1'b0;
        if (valid_r && (opcode_r == OPC_LOAD) && (rd_r != 5'd0) &&
            ((rs1_use_s && (rs1_s == rd_r)) || (rs2_use_s && (rs2_s == rd_r)))) begin
            hazard_s = 1'b1;
        end else if ((cnt_r != 2'd0) && (load_rd_r != 5'd0) &&
                     ((rs1_use_s && (rs1_s == load_rd_r)) ||
                      (rs2_use_s && (rs2_s == load_rd_r)))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign ready_o = (~valid_r | ready_i) & ~hazard_s & ~flush_i;

    // Operand selection: x0 reads zero, same-cycle writeback overrides the regfile
    always_comb begin
        op_a_s = rs1_data_i;
        op_b_s = rs2_data_i;
        if (rs1_s == 5'd0) begin
            op_a_s = {XLEN{1'b0}};
        end else if (wb_we_i && (wb_rd_i == rs1_s)) begin
            op_a_s = wb_data_i;
        end else begin
            op_a_s = rs1_data_i;
        end
        if (rs2_s == 5'd0) begin
            op_b_s = {XLEN{1'b0}};
        end else if (wb_we_i && (wb_rd_i == rs2_s)) begin
            op_b_s = wb_data_i;
        end else begin
            op_b_s = rs2_data_i;
        end
    end

    // Pipeline register; payload only changes on an accepted instruction
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_r     <= 1'b0;
            pc_r        <= {XLEN{1'b0}};
            op_a_r      <= {XLEN{1'b0}};
            op_b_r      <= {XLEN{1'b0}};
            imm_r       <= {XLEN{1'b0}};
            rd_r        <= 5'd0;
            opcode_r    <= 7'd0;
            funct3_r    <= 3'd0;
            funct7b5_r  <= 1'b0;
            reg_write_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
        end else if (fire_in_s) begin
            valid_r     <= 1'b1;
            pc_r        <= pc_i;
            op_a_r      <= op_a_s;
            op_b_r      <= op_b_s;
            imm_r       <= XLEN'($signed(imm_s));
            rd_r        <= reg_write_s ? instr_i[11:7] : 5'd0;
            opcode_r    <= opcode_s;
            funct3_r    <= instr_i[14:12];
            funct7b5_r  <= instr_i[30];
            reg_write_r <= reg_write_s;
            illegal_r   <= ~legal_s;
        end else if (ready_i) begin
            valid_r <= 1'b0;
        end
    end

    // Tracker that keeps dependents held for LOAD_LAT cycles after a load leaves
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_rd_r <= 5'd0;
            cnt_r     <= 2'd0;
        end else if (flush_i) begin
            cnt_r <= 2'd0;
        end else if (fire_out_s && (opcode_r == OPC_LOAD) && (rd_r != 5'd0)) begin
            load_rd_r <= rd_r;
            cnt_r     <= LOAD_LAT_C;
        end else if (cnt_r != 2'd0) begin
            cnt_r <= cnt_r - 2'd1;
        end
    end

    assign rs1_o       = rs1_s;
    assign rs2_o       = rs2_s;
    assign valid_o     = valid_r;
    assign pc_o        = pc_r;
    assign op_a_o      = op_a_r;
    assign op_b_o      = op_b_r;
    assign imm_o       = imm_r;
    assign rd_o        = rd_r;
    assign opcode_o    = opcode_r;
    assign funct3_o    = funct3_r;
    assign funct7b5_o  = funct7b5_r;
    assign reg_write_o = reg_write_r;
    assign illegal_o   = illegal_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: expected outputs are modelled from
// the driven instruction and compared when the stage hands the result on.
module tb_id_operand_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
        logic        rw;
        logic        ill;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i, ready_o, flush_i, wb_we_i, valid_o, ready_i;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i, wb_data_i;
    logic [4:0]  rs1_o, rs2_o, wb_rd_i, rd_o;
    logic [31:0] pc_o, op_a_o, op_b_o, imm_o;
    logic [6:0]  opcode_o;
    logic [2:0]  funct3_o;
    logic        funct7b5_o, reg_write_o, illegal_o;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [31:0] regs [32];
    logic [31:0] pc_ctr = 32'h0000_0100;
    logic        acc;

    id_operand_stage #(.LOAD_LAT(1), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wb_we_i(wb_we_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .valid_o(valid_o), .ready_i(ready_i),
        .pc_o(pc_o), .op_a_o(op_a_o), .op_b_o(op_b_o), .imm_o(imm_o), .rd_o(rd_o),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
        .reg_write_o(reg_write_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] d1, input logic [31:0] d2,
                                   input logic we, input logic [4:0] wrd,
                                   input logic [31:0] wd);
        exp_t e;
        logic [4:0] r1, r2;
        r1     = ins[19:15];
        r2     = ins[24:20];
        e.pc   = pc;
        e.op_a = (r1 == 5'd0) ? 32'd0 : ((we && wrd == r1) ? wd : d1);
        e.op_b = (r2 == 5'd0) ? 32'd0 : ((we && wrd == r2) ? wd : d2);
        e.opc  = ins[6:0];
        e.f3   = ins[14:12];
        e.f7b5 = ins[30];
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: e.imm = {{20{ins[31]}}, ins[31:20]};
            7'h23: e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            7'h63: e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            7'h37, 7'h17: e.imm = {ins[31:12], 12'd0};
            7'h6F: e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: e.imm = 32'd0;
        endcase
        case (ins[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: e.rw = 1'b1;
            default: e.rw = 1'b0;
        endcase
        case (ins[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73:
                e.ill = 1'b0;
            default: e.ill = 1'b1;
        endcase
        e.rd = e.rw ? ins[11:7] : 5'd0;
        return e;
    endfunction

    task automatic compare_out(input exp_t e);
        check_val("pc", pc_o, e.pc);
        check_val("op_a", op_a_o, e.op_a);
        check_val("op_b", op_b_o, e.op_b);
        check_val("imm", imm_o, e.imm);
        check_val("rd", {27'd0, rd_o}, {27'd0, e.rd});
        check_val("opcode", {25'd0, opcode_o}, {25'd0, e.opc});
        check_val("funct3", {29'd0, funct3_o}, {29'd0, e.f3});
        check_val("funct7b5", {31'd0, funct7b5_o}, {31'd0, e.f7b5});
        check_val("reg_write", {31'd0, reg_write_o}, {31'd0, e.rw});
        check_val("illegal", {31'd0, illegal_o}, {31'd0, e.ill});
    endtask

    // One clock of stimulus; exp_rdy < 0 means ready_o is not checked this cycle
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy,
                         input logic fl, input logic we, input logic [4:0] wrd,
                         input logic [31:0] wd, input int exp_rdy, output logic accepted);
        valid_i    = v;
        instr_i    = ins;
        pc_i       = pc_ctr;
        ready_i    = rdy;
        flush_i    = fl;
        wb_we_i    = we;
        wb_rd_i    = wrd;
        wb_data_i  = wd;
        rs1_data_i = regs[ins[19:15]];
        rs2_data_i = regs[ins[24:20]];
        #1;
        check_val("valid_o", {31'd0, valid_o}, {31'd0, sb_q.size() != 0});
        if (exp_rdy >= 0) check_val("ready_o", {31'd0, ready_o}, exp_rdy);
        check_val("rs1_o", {27'd0, rs1_o}, {27'd0, ins[19:15]});
        check_val("rs2_o", {27'd0, rs2_o}, {27'd0, ins[24:20]});
        if (valid_o && sb_q.size() != 0) compare_out(sb_q[0]);
        if ((valid_o && rdy) || (valid_o && fl)) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        accepted = v & ready_o;
        if (accepted) sb_q.push_back(model(ins, pc_ctr, rs1_data_i, rs2_data_i, we, wrd, wd));
        @(posedge clk_i);
        @(negedge clk_i);
        if (accepted) pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, -1, acc);
    endtask

    logic [31:0] tbl [10];
    int          idx;
    int          budget;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h10 * i;
        regs[0]  = 32'hDEAD_BEEF;
        rst_n_i  = 1'b0;
        valid_i  = 1'b0; instr_i = 32'd0; pc_i = 32'd0; flush_i = 1'b0; ready_i = 1'b0;
        wb_we_i  = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
        rs1_data_i = 32'd0; rs2_data_i = 32'd0;
        repeat (2) @(negedge clk_i);
        check_val("rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("rst_op_a", op_a_o, 32'd0);
        check_val("rst_rd", {27'd0, rd_o}, 32'd0);
        check_val("rst_rw", {31'd0, reg_write_o}, 32'd0);
        rst_n_i = 1'b1;

        // ADDI x5,x0,7 then ADD x3,x1,x2 with writeback to x2 bypassed
        cycle(1'b1, 32'h0070_0293, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        idle(1);
        cycle(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b1, 5'd2, 32'h55, 1, acc);
        idle(1);

        // LW x4,0(x1) followed by dependent ADD x6,x4,x4
        cycle(1'b1, 32'h0000_A203, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        cycle(1'b1, 32'h0042_0333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 0, acc);
        cycle(1'b1, 32'h0042_0333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 0, acc);
        cycle(1'b1, 32'h0042_0333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        idle(1);

        // Output hold under back-pressure, then same-cycle accept on release
        cycle(1'b1, 32'hFFF0_8393, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        cycle(1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 0, acc);
        cycle(1'b1, 32'h1234_5537, 1'b0, 1'b0, 1'b1, 5'd1, 32'h77, 0, acc);
        cycle(1'b1, 32'h0020_A423, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 0, acc);
        cycle(1'b1, 32'h0F01_6413, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        idle(1);

        // Flush kills both the held and the incoming instruction
        cycle(1'b1, 32'h0010_0493, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        cycle(1'b1, 32'h0070_0293, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 0, acc);
        idle(1);

        // Flush as a load leaves cancels the load-use countdown
        cycle(1'b1, 32'h0000_A203, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        cycle(1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 0, acc);
        cycle(1'b1, 32'h0042_0333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        idle(1);

        // Negative branch offset and an illegal opcode
        cycle(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        cycle(1'b1, 32'h0000_037F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        idle(1);

        // Mixed stream with random back-pressure and writeback traffic
        tbl[0] = 32'h1234_5537; tbl[1] = 32'hFF9F_F0EF; tbl[2] = 32'h0020_A423;
        tbl[3] = 32'h0000_A203; tbl[4] = 32'h0012_02B3; tbl[5] = 32'hFE20_8EE3;
        tbl[6] = 32'h0000_007F; tbl[7] = 32'h0000_1517; tbl[8] = 32'h0042_00E7;
        tbl[9] = 32'h4030_D293;
        idx    = 0;
        budget = 200;
        while (idx < 10 && budget > 0) begin
            cycle(1'b1, tbl[idx], 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom, -1, acc);
            if (acc) idx++;
            budget--;
        end
        check_val("stream_budget", idx, 32'd10);
        idle(4);
        check_val("sb_empty", sb_q.size(), 32'd0);

        // Asynchronous reset mid-operation clears the stage immediately
        cycle(1'b1, 32'h0070_0293, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1, acc);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_val("async_rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("async_rst_imm", imm_o, 32'd0);
        sb_q.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
